// File: rtl/io_sevenseg_driver.sv
// rtl/io_sevenseg_driver.sv - 8-digit multiplexed seven-segment driver with hex and double-dabble decimal modes
module io_sevenseg_driver #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic [31:0] data_in,
    input  logic        dec_mode,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic        busy,
    output logic        ovf
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   cap_val_q, cap_val_d;
    logic          cap_mode_q, cap_mode_d;
    logic [31:0]   disp_q, disp_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   bin_q, bin_d;
    logic [39:0]   bcd_q, bcd_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;
    logic [39:0]   bcd_adj;

    // Active-low {g..a} glyph for one hex nibble
    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            default: glyph = 7'h0E;
        endcase
    endfunction

    // Double-dabble correction: every BCD digit >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < 10; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Capture FSM: latch new input, show hex directly or run the 32-step conversion
    always_comb begin
        state_d    = state_q;
        cap_val_d  = cap_val_q;
        cap_mode_d = cap_mode_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if ((data_in != cap_val_q) || (dec_mode != cap_mode_q)) begin
                    cap_val_d  = data_in;
                    cap_mode_d = dec_mode;
                    if (dec_mode) begin
                        bin_d   = data_in;
                        bcd_d   = 40'd0;
                        cnt_d   = 5'd0;
                        state_d = S_SHIFT;
                    end else begin
                        disp_d = data_in;
                        ovf_d  = 1'b0;
                    end
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj[38:0], bin_q, 1'b0};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                disp_d  = bcd_q[31:0];
                ovf_d   = |bcd_q[39:32];
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Scan timing plus digit decode; an and seg come from the same next-state so they switch together
    always_comb begin
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 3'd1;
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end
        an_d = ~(8'd1 << idx_d);
        if (cap_mode_d && (idx_d != 3'd0) && ((disp_d >> {idx_d, 2'b00}) == 32'd0)) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = {~((idx_d == 3'd7) && cap_mode_d && ovf_d), glyph(disp_d[{idx_d, 2'b00} +: 4])};
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!clrn) begin
            state_q    <= S_IDLE;
            cap_val_q  <= 32'd0;
            cap_mode_q <= 1'b0;
            disp_q     <= 32'd0;
            ovf_q      <= 1'b0;
            bin_q      <= 32'd0;
            bcd_q      <= 40'd0;
            cnt_q      <= 5'd0;
            presc_q    <= '0;
            idx_q      <= 3'd0;
            an_q       <= 8'hFE;
            seg_q      <= 8'hC0;
        end else begin
            state_q    <= state_d;
            cap_val_q  <= cap_val_d;
            cap_mode_q <= cap_mode_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign busy = (state_q != S_IDLE);
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_io_sevenseg_driver.sv
// tb/tb_io_sevenseg_driver.sv - directed scoreboard bench for io_sevenseg_driver
module tb_io_sevenseg_driver;

    logic        clock = 1'b0;
    logic        clrn;
    logic [31:0] data_in;
    logic        dec_mode;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic        busy;
    logic        ovf;

    logic [31:0] exp_q[$];
    int          checks = 0;
    int          passes = 0;

    io_sevenseg_driver #(.SCAN_DIV(4)) dut (
        .clock   (clock),
        .clrn    (clrn),
        .data_in (data_in),
        .dec_mode(dec_mode),
        .an      (an),
        .seg     (seg),
        .busy    (busy),
        .ovf     (ovf)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] to_bcd(input int unsigned v);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [31:0] v, input logic m, input logic o, input int i);
        logic [3:0] n;
        logic [6:0] g;
        logic       dp;
        n = v[4*i +: 4];
        if (m && (i > 0) && ((v >> (4*i)) == 32'd0)) return 8'hFF;
        case (n)
            4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
            4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
            4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
            4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
        endcase
        dp = !((i == 7) && m && o);
        return {dp, g};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    endtask

    task automatic check_digits(input logic [31:0] v, input logic m, input logic o, input string tag);
        bit hit;
        for (int i = 0; i < 8; i++) exp_q.push_back({24'd0, exp_seg(v, m, o, i)});
        for (int i = 0; i < 8; i++) begin
            hit = 1'b0;
            for (int c = 0; c < 64; c++) begin
                @(negedge clock);
                if (an === ~(8'd1 << i)) begin
                    hit = 1'b1;
                    break;
                end
            end
            if (!hit) begin
                exp_q.push_front(32'd1);
                check($sformatf("%s_an%0d_timeout", tag, i), 32'd0);
                void'(exp_q.pop_front());
            end else begin
                check($sformatf("%s_seg%0d", tag, i), {24'd0, seg});
            end
        end
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        exp_q.push_back(32'd33);
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (busy === 1'b1) n++;
            else if (n > 0) break;
        end
        check(tag, n);
    endtask

    task automatic run_dec(input logic [31:0] v, input string tag);
        logic [31:0] d;
        logic        o;
        d = to_bcd(v);
        o = (v > 32'd99999999);
        data_in  = v;
        dec_mode = 1'b1;
        count_busy({tag, "_busy_cycles"});
        exp_q.push_back({31'd0, o});
        check({tag, "_ovf"}, {31'd0, ovf});
        check_digits(d, 1'b1, o, tag);
    endtask

    initial begin
        clrn     = 1'b0;
        data_in  = 32'd0;
        dec_mode = 1'b0;
        repeat (2) @(negedge clock);
        exp_q.push_back(32'hFE); check("reset_an", {24'd0, an});
        exp_q.push_back(32'hC0); check("reset_seg", {24'd0, seg});
        exp_q.push_back(32'd0);  check("reset_busy", {31'd0, busy});
        exp_q.push_back(32'd0);  check("reset_ovf", {31'd0, ovf});
        clrn = 1'b1;

        for (int k = 1; k <= 8; k++) begin
            exp_q.push_back({24'd0, ~(8'd1 << (k % 8))});
            repeat (4) @(negedge clock);
            check($sformatf("scan_step%0d", k), {24'd0, an});
        end

        data_in = 32'h1234ABCF;
        @(negedge clock);
        exp_q.push_back(32'd0); check("hex_busy", {31'd0, busy});
        exp_q.push_back(32'd0); check("hex_ovf", {31'd0, ovf});
        check_digits(32'h1234ABCF, 1'b0, 1'b0, "hex");

        run_dec(32'd12345678, "dec12345678");
        run_dec(32'd42, "dec42");
        run_dec(32'hFFFFFFFF, "decmax");

        data_in  = 32'd5;
        dec_mode = 1'b1;
        repeat (10) @(negedge clock);
        data_in = 32'd7;
        repeat (10) @(negedge clock);
        exp_q.push_back(32'd1); check("abort_busy_before_reset", {31'd0, busy});
        clrn = 1'b0;
        @(negedge clock);
        exp_q.push_back(32'd0);  check("abort_busy", {31'd0, busy});
        exp_q.push_back(32'd0);  check("abort_ovf", {31'd0, ovf});
        exp_q.push_back(32'hFE); check("abort_an", {24'd0, an});
        exp_q.push_back(32'hC0); check("abort_seg", {24'd0, seg});
        clrn = 1'b1;
        count_busy("abort_reconv_busy_cycles");
        exp_q.push_back(32'd0); check("abort_reconv_ovf", {31'd0, ovf});
        check_digits(32'h00000007, 1'b1, 1'b0, "abort_reconv");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
